// File: rtl/mac_int_pkg.sv
// ---------------------------------------------------------------------------
// mac_int_pkg
// Shared definitions for the MAC issuer slice: operand and accumulator
// widths plus the issuer FSM state encoding.
// Contents:
//   DATA_W  - operand width (signed A/B)
//   ACC_W   - MAC result width (signed)
//   state_t - issuer FSM states IDLE/ISSUE/WAIT/HOLD
// ---------------------------------------------------------------------------
package mac_int_pkg;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/mac_int_fifo.sv
// ---------------------------------------------------------------------------
// mac_int_fifo
// Small synchronous FIFO holding operand pairs waiting to be issued.
// Head data is presented combinationally from the read pointer.
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous active-high reset (FIFO becomes empty)
//   i_push  - write request, ignored while full
//   i_data  - write data
//   i_pop   - read request, ignored while empty
//   o_data  - current head entry
//   o_full  - no free entry
//   o_empty - no stored entry
// Parameters: DEPTH (power of 2, >=2), WIDTH (entry width)
// ---------------------------------------------------------------------------
module mac_int_fifo
  import mac_int_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2 * DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic             w_doPush;
  logic             w_doPop;

  // Pointers carry one extra wrap bit so full and empty can be told apart
  // when the index bits are equal.
  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                    (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_data   = r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + {{AW{1'b0}}, 1'b1};
      if (w_doPop)  r_rdPtr <= r_rdPtr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/mac_int_issuer.sv
// ---------------------------------------------------------------------------
// mac_int_issuer
// Buffers signed operand pairs in a FIFO and issues them one at a time to an
// external multiply-accumulate unit, then holds each result until the
// downstream consumer takes it.
// Ports:
//   clk, reset            - clock (rising edge), async active-high reset
//   in_valid/in_ready     - operand pair handshake, in_a/in_b signed 16-bit
//   mac_valid             - one-cycle issue pulse, mac_a/mac_b held operands
//   mac_y/mac_done        - signed 32-bit result from the MAC and its strobe
//   res_valid/res_ready   - result handshake, res_data signed 32-bit
//   busy                  - FSM is not idle
//   timeout               - sticky flag: an operation was abandoned
// Parameters: FIFO_DEPTH, TIMEOUT_CYCLES
// Build option: define MAC_ISSUER_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles without mac_done; otherwise timeout is tied low.
// ---------------------------------------------------------------------------
module mac_int_issuer
  import mac_int_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              mac_valid,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic [ACC_W-1:0]  mac_y,
  input  logic              mac_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              busy,
  output logic              timeout
);

  state_t              r_state;
  logic                r_macValid;
  logic [DATA_W-1:0]   r_macA;
  logic [DATA_W-1:0]   r_macB;
  logic                r_resValid;
  logic [ACC_W-1:0]    r_resData;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [2*DATA_W-1:0] w_head;

`ifdef MAC_ISSUER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_waitCnt;
  logic             r_timeout;
  assign timeout = r_timeout;
`else
  logic w_unusedTimeoutCfg;
  assign w_unusedTimeoutCfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // The FSM only enters ISSUE with a non-empty FIFO and nothing else pops,
  // so popping unconditionally in ISSUE always removes the issued pair.
  assign w_push    = in_valid && !w_full;
  assign w_pop     = (r_state == ST_ISSUE);
  assign in_ready  = !w_full;
  assign mac_valid = r_macValid;
  assign mac_a     = r_macA;
  assign mac_b     = r_macB;
  assign res_valid = r_resValid;
  assign res_data  = r_resData;
  assign busy      = (r_state != ST_IDLE);

  mac_int_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2 * DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  ({in_a, in_b}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Issuer FSM with registered outputs. The issue pulse and operands are
  // loaded on the edge that leaves ISSUE, so mac_valid is visible during the
  // first WAIT cycle and the operands stay put until the next issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_macValid <= 1'b0;
      r_macA     <= '0;
      r_macB     <= '0;
      r_resValid <= 1'b0;
      r_resData  <= '0;
`ifdef MAC_ISSUER_TIMEOUT_EN
      r_waitCnt  <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_macValid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) r_state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          r_macValid <= 1'b1;
          r_macA     <= w_head[2*DATA_W-1:DATA_W];
          r_macB     <= w_head[DATA_W-1:0];
          r_state    <= ST_WAIT;
`ifdef MAC_ISSUER_TIMEOUT_EN
          r_waitCnt  <= '0;
`endif
        end
        ST_WAIT: begin
          if (mac_done) begin
            r_resData  <= mac_y;
            r_resValid <= 1'b1;
            r_state    <= ST_HOLD;
          end
`ifdef MAC_ISSUER_TIMEOUT_EN
          // The counter shows how many WAIT cycles have already elapsed, so
          // the last permitted cycle is the one where it reads TIMEOUT_CYCLES-1.
          else if (r_waitCnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_waitCnt <= r_waitCnt + {{(TMO_W-1){1'b0}}, 1'b1};
          end
`endif
        end
        ST_HOLD: begin
          if (res_ready) begin
            r_resValid <= 1'b0;
            r_state    <= w_empty ? ST_IDLE : ST_ISSUE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_int_issuer.sv
// ---------------------------------------------------------------------------
// tb_mac_int_issuer
// Directed bench for mac_int_issuer with a MAC stub that returns A*B three
// cycles after each issue pulse. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_mac_int_issuer;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [15:0]        in_a;
  logic [15:0]        in_b;
  logic               mac_valid;
  logic [15:0]        mac_a;
  logic [15:0]        mac_b;
  logic [31:0]        mac_y;
  logic               mac_done;
  logic               res_valid;
  logic               res_ready;
  logic [31:0]        res_data;
  logic               busy;
  logic               timeout;

  int checkCount = 0;
  int errorCount = 0;

  // MAC stub: result registered at the issue pulse, done strobe three
  // cycles after the pulse; stubOn=0 models a MAC that never answers.
  logic               stubOn = 1'b1;
  logic [2:0]         stubPipe = 3'b000;
  logic signed [31:0] stubY = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    stubPipe <= {stubPipe[1:0], mac_valid & stubOn};
    if (mac_valid && stubOn) stubY <= $signed(mac_a) * $signed(mac_b);
  end

  assign mac_done = stubPipe[2];
  assign mac_y    = stubY;

  mac_int_issuer #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mac_valid (mac_valid),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_y     (mac_y),
    .mac_done  (mac_done),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy),
    .timeout   (timeout)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               tag, observed, observed, expected, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " mac_valid"}, 32'(mac_valid), 32'd0);
    checkOutput({tag, " mac_a"},     32'(mac_a),     32'd0);
    checkOutput({tag, " mac_b"},     32'(mac_b),     32'd0);
    checkOutput({tag, " res_valid"}, 32'(res_valid), 32'd0);
    checkOutput({tag, " res_data"},  res_data,       32'd0);
    checkOutput({tag, " busy"},      32'(busy),      32'd0);
    checkOutput({tag, " timeout"},   32'(timeout),   32'd0);
  endtask

  // Push one pair, waiting a bounded time for space in the FIFO.
  task automatic applyStimulus(input int a, input int b);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    checkOutput("push in_ready", 32'(in_ready), 32'd1);
    in_a     = 16'(a);
    in_b     = 16'(b);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitResValid(input string tag);
    int n = 0;
    while (!res_valid && n < 200) begin
      tick();
      n++;
    end
    checkOutput({tag, " res_valid seen"}, 32'(res_valid), 32'd1);
  endtask

  task automatic waitMacValid(input string tag);
    int n = 0;
    while (!mac_valid && n < 200) begin
      tick();
      n++;
    end
    checkOutput({tag, " mac_valid seen"}, 32'(mac_valid), 32'd1);
  endtask

  // Wait for a result, compare it and accept it with a one-cycle res_ready.
  task automatic collectResult(input string tag, input int expected);
    waitResValid(tag);
    checkOutput({tag, " res_data"}, res_data, 32'(expected));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  int aList [5] = '{30, 10, 50, 100, 100};
  int bList [5] = '{40, 16, 25, 23, 24};
  int yList [5] = '{1200, 160, 1250, 2300, 2400};
  int naList [3] = '{100, -111, 40};
  int nbList [3] = '{-2, -2, -50};
  int nyList [3] = '{-200, 222, -2000};

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    checkResetState("reset");
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);

    // Single pair: push edge E0, issue pulse visible after E2,
    // done after E5, result held after E6.
    in_a = 16'd30; in_b = 16'd40; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checkOutput("single E0 mac_valid", 32'(mac_valid), 32'd0);
    checkOutput("single E0 busy", 32'(busy), 32'd0);
    tick();
    checkOutput("single E1 mac_valid", 32'(mac_valid), 32'd0);
    checkOutput("single E1 busy", 32'(busy), 32'd1);
    tick();
    checkOutput("single E2 mac_valid", 32'(mac_valid), 32'd1);
    checkOutput("single E2 mac_a", 32'(mac_a), 32'd30);
    checkOutput("single E2 mac_b", 32'(mac_b), 32'd40);
    tick();
    checkOutput("single E3 mac_valid", 32'(mac_valid), 32'd0);
    checkOutput("single E3 mac_a held", 32'(mac_a), 32'd30);
    tick();
    tick();
    checkOutput("single E5 res_valid", 32'(res_valid), 32'd0);
    tick();
    checkOutput("single E6 res_valid", 32'(res_valid), 32'd1);
    checkOutput("single E6 res_data", res_data, 32'd1200);
    tick();
    checkOutput("single E7 res_valid held", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput("single accept res_valid", 32'(res_valid), 32'd0);
    checkOutput("single accept busy", 32'(busy), 32'd0);

    // Five pairs back-to-back: one is issued after the third push, so the
    // FIFO holds four (full) after the fifth; extra pushes are dropped.
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("burst in_ready %0d", i), 32'(in_ready), 32'd1);
      in_a = 16'(aList[i]);
      in_b = 16'(bList[i]);
      in_valid = 1'b1;
      tick();
    end
    in_a = 16'd999; in_b = 16'd999;
    checkOutput("burst full in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput($sformatf("burst stay full %0d", i), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++)
      collectResult($sformatf("burst result %0d", i), yList[i]);
    repeat (8) tick();
    checkOutput("burst no extra op busy", 32'(busy), 32'd0);
    checkOutput("burst no extra res_valid", 32'(res_valid), 32'd0);

    // Signed operands.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(naList[i], nbList[i]);
      collectResult($sformatf("neg %0d", i), nyList[i]);
    end

    // Result stall in HOLD with a second pair queued.
    applyStimulus(7, 8);
    applyStimulus(9, 10);
    waitResValid("stall");
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("stall %0d res_valid", i), 32'(res_valid), 32'd1);
      checkOutput($sformatf("stall %0d res_data", i), res_data, 32'd56);
      checkOutput($sformatf("stall %0d mac_valid", i), 32'(mac_valid), 32'd0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput("stall release res_valid", 32'(res_valid), 32'd0);
    checkOutput("stall release busy", 32'(busy), 32'd1);
    checkOutput("stall release mac_valid", 32'(mac_valid), 32'd0);
    tick();
    checkOutput("stall reissue mac_valid", 32'(mac_valid), 32'd1);
    checkOutput("stall reissue mac_a", 32'(mac_a), 32'd9);
    checkOutput("stall reissue mac_b", 32'(mac_b), 32'd10);
    collectResult("stall second", 90);

    // Reset while waiting; the stub's late done strobe must be ignored.
    applyStimulus(5, 6);
    waitMacValid("rst");
    tick();
    checkOutput("rst in WAIT busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkResetState("rst async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("rst after %0d res_valid", i), 32'(res_valid), 32'd0);
      checkOutput($sformatf("rst after %0d busy", i), 32'(busy), 32'd0);
    end
    checkResetState("rst settled");
    checkOutput("rst settled in_ready", 32'(in_ready), 32'd1);

`ifdef MAC_ISSUER_TIMEOUT_EN
    // Unresponsive MAC: abort after 16 WAIT cycles, then recover.
    stubOn = 1'b0;
    applyStimulus(3, 4);
    waitMacValid("tmo");
    repeat (15) tick();
    checkOutput("tmo before timeout", 32'(timeout), 32'd0);
    checkOutput("tmo before busy", 32'(busy), 32'd1);
    tick();
    checkOutput("tmo timeout set", 32'(timeout), 32'd1);
    checkOutput("tmo busy clear", 32'(busy), 32'd0);
    checkOutput("tmo no res_valid", 32'(res_valid), 32'd0);
    stubOn = 1'b1;
    applyStimulus(6, 7);
    collectResult("tmo recover", 42);
    checkOutput("tmo sticky", 32'(timeout), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

  initial begin
    #200000;
    errorCount++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
